// File: rtl/aes_pkg.sv
// ----------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the sequential AES (Inv)MixColumns engine:
//   - byte / column / state typedefs
//   - FSM state encoding of the engine
//   - coefficient-select codes d = (source row - output row) mod 4
//   - xtime (multiply by 2 in GF(2^8), AES polynomial 0x11b)
//   - state_byte: extracts byte j of a column-major 128-bit state
//     (byte 0 sits in [127:120], byte 15 in [7:0])
// ----------------------------------------------------------------------------
package aes_pkg;

    typedef logic [7:0]   byte_t;
    typedef logic [31:0]  col_t;
    typedef logic [127:0] state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mix_state_e;

    // Inverse coefficients: D0 -> 14, D1 -> 11, D2 -> 13, D3 -> 9
    // Forward coefficients: D0 -> 2,  D1 -> 3,  D2 -> 1,  D3 -> 1
    localparam logic [1:0] SEL_D0 = 2'd0;
    localparam logic [1:0] SEL_D1 = 2'd1;
    localparam logic [1:0] SEL_D2 = 2'd2;
    localparam logic [1:0] SEL_D3 = 2'd3;

    function automatic byte_t xtime(input byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic byte_t state_byte(input state_t s, input logic [3:0] idx);
        return s[8*(15 - int'(idx)) +: 8];
    endfunction

endpackage

// File: rtl/inv_mix_coeff_sel.sv
// ----------------------------------------------------------------------------
// inv_mix_coeff_sel
// Combinational product selector for one output row. Given the coefficient
// select d and the ROM products of the current source byte, returns the byte
// that is XORed into that output row. With fwd=1 the forward MixColumns
// coefficients are produced from the raw byte via xtime instead.
// Ports:
//   d        coefficient select (source row - output row) mod 4
//   rom9b    {9*a, 11*a}
//   romde    {13*a, 14*a}
//   raw      the source byte a itself
//   fwd      1 = forward MixColumns, 0 = InvMixColumns
//   product  selected GF(2^8) product
// ----------------------------------------------------------------------------
module inv_mix_coeff_sel
    import aes_pkg::*;
(
    input  logic [1:0]  d,
    input  logic [15:0] rom9b,
    input  logic [15:0] romde,
    input  byte_t       raw,
    input  logic        fwd,
    output byte_t       product
);

    byte_t raw_x2;

    assign raw_x2 = xtime(raw);

    always_comb begin
        product = '0;
        if (fwd) begin
            case (d)
                SEL_D0:  product = raw_x2;
                SEL_D1:  product = raw_x2 ^ raw;
                default: product = raw;
            endcase
        end else begin
            case (d)
                SEL_D0:  product = romde[7:0];
                SEL_D1:  product = rom9b[7:0];
                SEL_D2:  product = romde[15:8];
                default: product = rom9b[15:8];
            endcase
        end
    end

endmodule

// File: rtl/inv_mix_columns_seq.sv
// ----------------------------------------------------------------------------
// inv_mix_columns_seq
// Sequential AES InvMixColumns engine. Accepts one 128-bit state on a
// valid/ready handshake, streams its 16 bytes one per cycle to the registered
// x9/x11 and x13/x14 product ROMs, accumulates the returned products per
// column, and presents the result on a second valid/ready handshake.
// out_valid rises 17 cycles after the accepting edge.
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready       input handshake, state_in column-major
//   rom_add, rom_en         address and read enable to both ROMs
//   rom9b_dout, romde_dout  registered ROM products {9a,11a}, {13a,14a}
//   out_valid/out_ready     output handshake, state_out same byte order
// Optional macro MIX_COLUMNS_FWD_EN adds input fwd (sampled at accept) that
// selects forward MixColumns computed from the raw bytes.
// ----------------------------------------------------------------------------
module inv_mix_columns_seq
    import aes_pkg::*;
#(
    parameter int ROM_LAT = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
`ifdef MIX_COLUMNS_FWD_EN
    input  logic         fwd,
`endif
    output logic [7:0]   rom_add,
    output logic         rom_en,
    input  logic [15:0]  rom9b_dout,
    input  logic [15:0]  romde_dout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out
);

    mix_state_e  state;
    state_t      state_q;
    logic [3:0]  k;
    logic        fwd_q;

    // Pipes aligned with the ROM read latency: whether a read was issued,
    // which byte it was and the raw byte value.
    logic        vld_pipe [ROM_LAT];
    logic [3:0]  idx_pipe [ROM_LAT];
    byte_t       raw_pipe [ROM_LAT];

    logic        vld_tap;
    logic [3:0]  idx_tap;
    byte_t       raw_tap;

    byte_t       acc      [16];
    byte_t       next_acc [16];
    byte_t       prod     [4];
    state_t      next_packed;

    assign vld_tap = vld_pipe[ROM_LAT-1];
    assign idx_tap = idx_pipe[ROM_LAT-1];
    assign raw_tap = raw_pipe[ROM_LAT-1];

`ifndef MIX_COLUMNS_FWD_EN
    assign fwd_q = 1'b0;
`endif

    // One product selector per output row of the column being accumulated.
    for (genvar r = 0; r < 4; r++) begin : g_row
        logic [1:0] d_sel;
        assign d_sel = idx_tap[1:0] - 2'(r);
        inv_mix_coeff_sel u_sel (
            .d       (d_sel),
            .rom9b   (rom9b_dout),
            .romde   (romde_dout),
            .raw     (raw_tap),
            .fwd     (fwd_q),
            .product (prod[r])
        );
    end

    // Accumulator update for the byte whose ROM data is present this cycle:
    // all four rows of its column take their product at once.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            next_acc[i] = acc[i];
        end
        for (int r = 0; r < 4; r++) begin
            next_acc[{idx_tap[3:2], 2'(r)}] = acc[{idx_tap[3:2], 2'(r)}] ^ prod[r];
        end
        next_packed = '0;
        for (int i = 0; i < 16; i++) begin
            next_packed[8*(15-i) +: 8] = next_acc[i];
        end
    end

    // Control FSM, read pipeline and accumulators. The valid pipe is cleared
    // by reset so data still returning from the ROM is not accumulated.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            rom_en    <= 1'b0;
            rom_add   <= '0;
            state_out <= '0;
            state_q   <= '0;
            k         <= '0;
`ifdef MIX_COLUMNS_FWD_EN
            fwd_q     <= 1'b0;
`endif
            for (int i = 0; i < 16; i++) begin
                acc[i] <= '0;
            end
            for (int i = 0; i < ROM_LAT; i++) begin
                vld_pipe[i] <= 1'b0;
                idx_pipe[i] <= '0;
                raw_pipe[i] <= '0;
            end
        end else begin
            vld_pipe[0] <= rom_en;
            idx_pipe[0] <= k;
            raw_pipe[0] <= rom_add;
            for (int i = 1; i < ROM_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                idx_pipe[i] <= idx_pipe[i-1];
                raw_pipe[i] <= raw_pipe[i-1];
            end

            if (vld_tap) begin
                for (int i = 0; i < 16; i++) begin
                    acc[i] <= next_acc[i];
                end
            end

            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        state_q  <= state_in;
`ifdef MIX_COLUMNS_FWD_EN
                        fwd_q    <= fwd;
`endif
                        k        <= 4'd0;
                        rom_en   <= 1'b1;
                        rom_add  <= state_byte(state_in, 4'd0);
                        in_ready <= 1'b0;
                        for (int i = 0; i < 16; i++) begin
                            acc[i] <= '0;
                        end
                        state    <= READ;
                    end
                end
                READ: begin
                    if (k == 4'd15) begin
                        rom_en <= 1'b0;
                        state  <= DRAIN;
                    end else begin
                        k       <= k + 4'd1;
                        rom_add <= state_byte(state_q, k + 4'd1);
                    end
                end
                DRAIN: begin
                    if (vld_tap && idx_tap == 4'd15) begin
                        out_valid <= 1'b1;
                        state_out <= next_packed;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/inv_mix_columns_seq.md
Name: inv_mix_columns_seq

Overview:
- Sequential AES InvMixColumns engine acting as the reader/initiator for the registered GF(2^8) product ROMs.
- Streams the 16 state bytes one per cycle into the ×9/×11 ROM and the ×13/×14 ROM.
- Accumulates the returned products per column into a 128-bit result.
- Sits between the inverse round's AddRoundKey and InvShiftRows/InvSubBytes stages; uses valid/ready handshakes on both sides.

Parameters:
- ROM_LAT, 1, ROM read latency in cycles; equals the registered ROM output, fixed at 1 for this release.

Ports:
- clock  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  state_in valid.
- in_ready  output  1  engine can accept a state.
- state_in  input  128  AES state, column-major; [127:120]=byte0 (r0,c0), [119:112]=byte1 (r1,c0) … [7:0]=byte15 (r3,c3).
- rom_add  output  8  byte address driven to both ROMs.
- rom_en  output  1  read enable to both ROMs.
- rom9b_dout  input  16  [15:8]=9·a, [7:0]=11·a.
- romde_dout  input  16  [15:8]=13·a, [7:0]=14·a.
- out_valid  output  1  state_out valid.
- out_ready  input  1  consumer accepts state_out.
- state_out  output  128  InvMixColumns(state_in), same byte order.

Behaviour:
- Reset values: in_ready=0 during reset then 1 in IDLE; out_valid=0, rom_en=0, rom_add=0, state_out=0, accumulators=0, FSM=IDLE.
- FSM IDLE -> READ -> DRAIN -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch state_in, clear accumulators, byte counter k=0, go READ.
- READ:
  - rom_en=1, rom_add=byte k, k increments each cycle.
  - After issuing k=15, go DRAIN.
  - in_ready=0.
- Accumulate:
  - ROM data for byte k is present one cycle after issue and is accumulated on the following edge.
  - Byte j (column c=j/4, row s=j%4) XORs into output row r of column c with coefficient by d=(s-r) mod 4: d0→14, d1→11, d2→13, d3→9.
  - All four rows update in the same cycle.
  - A valid-pipe bit tracks ROM_LAT so only issued reads are accumulated.
- DRAIN: accumulates byte 15; on that edge out_valid<=1, state_out<=accumulators, go DONE.
- Latency: out_valid rises exactly 17 cycles after the accepting edge.
- DONE:
  - out_valid held with state_out stable until out_valid&&out_ready.
  - Then out_valid<=0, go IDLE; in_ready returns 1 the cycle after.
  - No overlap of consecutive states; throughput is 1 state per ≥18 cycles.
- Arithmetic: pure XOR in GF(2^8), no carries; all widths 8-bit per byte.
- Reset asserted mid-READ/DRAIN/DONE:
  - Returns to reset values on that edge.
  - In-flight ROM data arriving the next cycle is discarded.
- in_valid while busy is ignored and not latched.
- out_ready while out_valid=0 has no effect.

Optional Feature:
- Macro MIX_COLUMNS_FWD_EN.
- When defined:
  - Adds input port fwd (1 bit), sampled at accept.
  - fwd=1 computes forward MixColumns with coefficients d0→2, d1→3, d2→1, d3→1.
  - Uses the raw byte (address delayed ROM_LAT cycles) and an internal xtime; ROM data is ignored but the ROMs are still read, so latency is unchanged.
- When undefined: no fwd port; inverse only.

Decomposition:
- Shared package aes_pkg holds:
  - byte/column/state typedefs;
  - the coefficient-select constants;
  - the xtime function;
  - the state byte-index helper.
- One sub-module, inv_mix_coeff_sel: combinational, maps (d, ROM products, raw byte, fwd) to the 8-bit product XORed into a row.

Test Plan:
- Bench uses ROM models loaded with the mixcols_9_b and mixcols_d_e tables. Each scenario below gives stimulus -> required response.
- state_in columns 8e4da1bc, 9f dc 58 9d (=9fdc589d), 01010101, c6c6c6c6 -> state_out columns db135345, f20a225c, 01010101, c6c6c6c6; out_valid exactly 17 cycles after accept; rom_add sequence byte0..15 on consecutive cycles.
- out_ready held 0 for 10 cycles after out_valid -> state_out and out_valid stable; in_ready=0; an in_valid pulse in that window is not accepted; after out_ready=1 the next state is accepted one cycle after release.
- Back-to-back in_valid with out_ready=1 -> accepts spaced ≥18 cycles; each result correct; no accumulator carry-over between states.
- reset pulsed at cycle 8 of READ -> next cycle all outputs at reset values; subsequent state 8e4da1bc… yields correct result with no contamination.
- MIX_COLUMNS_FWD_EN build, fwd=1, columns db135345, f20a225c -> 8e4da1bc, 9fdc589d; fwd=0 reproduces scenario 1.
